// File: rtl/vram_arbiter.sv
// Two-master Wishbone arbiter for video memory: display fetch (m0) has priority,
// and the CPU (m1) is guaranteed the bus after STARVE consecutive m0 tenures.
module vram_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned STARVE = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_dat_m,
  output logic [DW-1:0]   m0_dat_s,
  output logic            m0_ack,
  output logic            m0_stall,

  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_dat_m,
  output logic [DW-1:0]   m1_dat_s,
  output logic            m1_ack,
  output logic            m1_stall,

  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_m,
  input  logic [DW-1:0]   s_dat_s,
  input  logic            s_ack,
  input  logic            s_stall
);

  localparam int unsigned CW = ($clog2(STARVE + 1) > 3) ? $clog2(STARVE + 1) : 3;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;

  // State and starvation counter; reset terminates any tenure immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Grant decision uses cyc only; grant is frozen for the whole tenure
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (!m1_cyc) starve_cnt_nxt = '0;
        if (m0_cyc && (!m1_cyc || (starve_cnt < STARVE_LIM))) begin
          state_nxt = GNT0;
        end else if (m1_cyc) begin
          state_nxt      = GNT1;
          starve_cnt_nxt = '0;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          state_nxt = IDLE;
          if (m1_cyc && (starve_cnt < STARVE_LIM)) starve_cnt_nxt = starve_cnt + CW'(1);
        end
      end
      GNT1: begin
        if (!m1_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus mux; slave responses reach only the granted master
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_m  = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;
    m0_dat_s = s_dat_s;
    m1_dat_s = s_dat_s;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_m  = m0_dat_m;
        m0_ack   = s_ack;
        m0_stall = s_stall;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_m  = m1_dat_m;
        m1_ack   = s_ack;
        m1_stall = s_stall;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: solo CPU access, priority, starvation relief,
// turnaround with stray ack, and asynchronous reset mid-tenure.
module tb_vram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [SW-1:0] m0_sel;
  logic [DW-1:0] m0_dat_m, m0_dat_s;
  logic          m0_ack, m0_stall;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [SW-1:0] m1_sel;
  logic [DW-1:0] m1_dat_m, m1_dat_s;
  logic          m1_ack, m1_stall;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_dat_m, s_dat_s;
  logic          s_ack, s_stall;

  int n_chk  = 0;
  int n_pass = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_m(m0_dat_m), .m0_dat_s(m0_dat_s), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_m(m1_dat_m), .m1_dat_s(m1_dat_s), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack), .s_stall(s_stall)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge, leaving settle margin
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i    = 1'b1;
    m0_cyc   = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m0_adr   = 32'h200; m0_sel = 4'hF; m0_dat_m = 32'hCAFE0000;
    m1_cyc   = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    m1_adr   = 32'h100; m1_sel = 4'h3; m1_dat_m = 32'hDEADBEEF;
    s_dat_s  = 32'h12345678; s_ack = 1'b1; s_stall = 1'b0;
    #2;
    check("rst_s_cyc", 64'(s_cyc), 64'd0);
    check("rst_s_adr", 64'(s_adr), 64'd0);
    check("rst_m0_ack", 64'(m0_ack), 64'd0);
    check("rst_m0_stall", 64'(m0_stall), 64'd1);
    check("rst_m1_stall", 64'(m1_stall), 64'd1);
    step();
    step();
    rst_i = 1'b0;
    s_ack = 1'b0;

    // Solo CPU write
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    #1;
    check("solo_idle_s_cyc", 64'(s_cyc), 64'd0);
    step();
    check("solo_s_cyc", 64'(s_cyc), 64'd1);
    check("solo_s_adr", 64'(s_adr), 64'h100);
    check("solo_s_dat_m", 64'(s_dat_m), 64'hDEADBEEF);
    check("solo_s_sel", 64'(s_sel), 64'h3);
    check("solo_m0_stall", 64'(m0_stall), 64'd1);
    s_ack = 1'b1;
    #1;
    check("solo_m1_ack", 64'(m1_ack), 64'd1);
    check("solo_m1_stall", 64'(m1_stall), 64'd0);
    check("solo_m0_ack", 64'(m0_ack), 64'd0);
    check("solo_m1_dat_s", 64'(m1_dat_s), 64'h12345678);
    s_ack  = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
    check("solo_end_s_cyc", 64'(s_cyc), 64'd0);

    // Simultaneous request: display fetch wins and holds regardless of stb
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check("sim_s_adr", 64'(s_adr), 64'h200);
    check("sim_s_dat_m", 64'(s_dat_m), 64'hCAFE0000);
    s_ack = 1'b1;
    #1;
    check("sim_m0_ack", 64'(m0_ack), 64'd1);
    check("sim_m1_ack", 64'(m1_ack), 64'd0);
    check("sim_m1_stall", 64'(m1_stall), 64'd1);
    m0_stb = 1'b0;
    step();
    check("nostb_s_cyc", 64'(s_cyc), 64'd1);
    check("nostb_s_stb", 64'(s_stb), 64'd0);
    check("nostb_s_adr", 64'(s_adr), 64'h200);
    check("nostb_m1_ack", 64'(m1_ack), 64'd0);
    s_ack  = 1'b0;
    m0_cyc = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    check("sim_end_s_cyc", 64'(s_cyc), 64'd0);

    // Starvation relief: four m0 tenures, then m1 with m0 still requesting
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      check($sformatf("starve_gnt%0d", t), 64'(s_adr), (t < 4) ? 64'h200 : 64'h100);
      if (t < 4) begin
        step();
        check($sformatf("starve_hold%0d", t), 64'(m1_stall), 64'd1);
        m0_cyc = 1'b0;
        step();
        check($sformatf("turn_s_cyc%0d", t), 64'(s_cyc), 64'd0);
        if (t == 3) begin
          s_ack = 1'b1;
          #1;
          check("stray_m0_ack", 64'(m0_ack), 64'd0);
          check("stray_m1_ack", 64'(m1_ack), 64'd0);
          s_ack = 1'b0;
        end
        m0_cyc = 1'b1;
      end
    end
    check("starve_m0_stall", 64'(m0_stall), 64'd1);
    s_stall = 1'b1;
    #1;
    check("starve_m1_stall", 64'(m1_stall), 64'd1);
    s_stall = 1'b0;
    #1;
    check("starve_m1_unstall", 64'(m1_stall), 64'd0);

    // Async reset during the m1 tenure, then m0 wins with counter cleared
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_s_cyc", 64'(s_cyc), 64'd0);
    check("arst_m1_stall", 64'(m1_stall), 64'd1);
    check("arst_s_adr", 64'(s_adr), 64'd0);
    step();
    #2;
    rst_i = 1'b0;
    #1;
    check("post_rst_idle", 64'(s_cyc), 64'd0);
    step();
    check("post_rst_s_adr", 64'(s_adr), 64'h200);
    check("post_rst_m1_stall", 64'(m1_stall), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
